// File: rtl/branch_predictor_ras.sv
// Fetch-stage branch predictor: direct-mapped BTB with per-entry saturating
// direction counters, a circular return-address stack and perf counters.
// Lookup is purely combinational on pre-edge state; EX resolution updates on clk_i.
module branch_predictor_ras #(
    parameter int unsigned ENTRIES   = 32,
    parameter int unsigned CNT_W     = 2,
    parameter int unsigned RAS_DEPTH = 8,
    parameter int unsigned PERF_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [31:0]       pc_i,
    output logic              hit_o,
    output logic [31:0]       predicted_pc_o,
    input  logic              valid_ex_i,
    input  logic [31:0]       inst_ex_i,
    input  logic [31:0]       pc_ex_i,
    input  logic              br_eq_i,
    input  logic              br_lt_i,
    input  logic [31:0]       alu_i,
    input  logic              hit_ex_i,
    input  logic [31:0]       pred_pc_ex_i,
    output logic [1:0]        wrong_predicted_o,
    output logic [31:0]       alu_pc_o,
    output logic [PERF_W-1:0] br_cnt_o,
    output logic [PERF_W-1:0] mispred_cnt_o
);

    localparam int unsigned IDX_W  = $clog2(ENTRIES);
    localparam int unsigned TAG_W  = 30 - IDX_W;
    localparam int unsigned RAS_PW = $clog2(RAS_DEPTH);
    localparam int unsigned RAS_CW = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] CntWeak = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CntMax  = '1;

    typedef enum logic [1:0] {KindBr, KindJmp, KindRet} kind_e;

    // BTB storage
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    kind_e              kind_q   [ENTRIES];
    logic [CNT_W-1:0]   cnt_q    [ENTRIES];

    // RAS storage; ptr points at the next free slot, top is ptr-1
    logic [31:0]        ras_q [RAS_DEPTH];
    logic [RAS_PW-1:0]  ras_ptr_q, ras_ptr_d, ras_top_idx, ras_widx;
    logic [RAS_CW-1:0]  ras_cnt_q, ras_cnt_d;
    logic               ras_we;

    logic [PERF_W-1:0]  br_cnt_q, mispred_cnt_q;

    // Lookup / decode signals
    logic [IDX_W-1:0]   lk_idx, ex_idx;
    logic [TAG_W-1:0]   lk_tag, ex_tag;
    logic               lk_match, ex_match;
    logic [6:0]         opcode;
    logic [4:0]         rd, rs1;
    logic [2:0]         funct3;
    logic               is_br, is_jal, is_jalr, is_ctrl, rd_link, rs1_link, br_cond, taken;
    logic               ras_push, ras_pop;
    kind_e              ex_kind;

    // BTB update fields for the EX index
    logic               btb_we;
    logic [TAG_W-1:0]   tag_d;
    logic [31:0]        target_d;
    kind_e              kind_d;
    logic [CNT_W-1:0]   cnt_d;

    assign lk_idx      = pc_i[IDX_W+1:2];
    assign lk_tag      = pc_i[31:IDX_W+2];
    assign ex_idx      = pc_ex_i[IDX_W+1:2];
    assign ex_tag      = pc_ex_i[31:IDX_W+2];
    assign ras_top_idx = ras_ptr_q - RAS_PW'(1);
    assign alu_pc_o    = alu_i;
    assign br_cnt_o    = br_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

    // Fetch lookup; RET hits take the RAS top when the stack holds anything
    always_comb begin
        lk_match       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        hit_o          = lk_match && ((kind_q[lk_idx] != KindBr) || cnt_q[lk_idx][CNT_W-1]);
        predicted_pc_o = target_q[lk_idx];
        if (lk_match && (kind_q[lk_idx] == KindRet) && (ras_cnt_q != '0)) begin
            predicted_pc_o = ras_q[ras_top_idx];
        end
    end

    // EX decode, branch resolution and mispredict classification
    always_comb begin
        opcode   = inst_ex_i[6:0];
        rd       = inst_ex_i[11:7];
        funct3   = inst_ex_i[14:12];
        rs1      = inst_ex_i[19:15];
        is_br    = (opcode == 7'b1100011);
        is_jal   = (opcode == 7'b1101111);
        is_jalr  = (opcode == 7'b1100111);
        is_ctrl  = is_br || is_jal || is_jalr;
        rd_link  = (rd == 5'd1) || (rd == 5'd5);
        rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);
        unique case (funct3)
            3'b000:  br_cond = br_eq_i;
            3'b001:  br_cond = !br_eq_i;
            3'b100:  br_cond = br_lt_i;
            3'b101:  br_cond = !br_lt_i;
            3'b110:  br_cond = br_lt_i;
            3'b111:  br_cond = !br_lt_i;
            default: br_cond = 1'b0;
        endcase
        taken    = (is_br && br_cond) || is_jal || is_jalr;
        if (is_jalr && rs1_link && !rd_link) begin
            ex_kind = KindRet;
        end else if (is_jal || is_jalr) begin
            ex_kind = KindJmp;
        end else begin
            ex_kind = KindBr;
        end
        ex_match = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

        wrong_predicted_o = 2'b00;
        if (valid_ex_i && is_ctrl) begin
            if (hit_ex_i && !taken) begin
                wrong_predicted_o = 2'b01;
            end else if (!hit_ex_i && taken) begin
                wrong_predicted_o = 2'b10;
            end else if (hit_ex_i && taken && (alu_i != pred_pc_ex_i)) begin
                wrong_predicted_o = 2'b10;
            end
        end
    end

    // Next BTB entry contents for the resolving instruction
    always_comb begin
        btb_we   = 1'b0;
        tag_d    = tag_q[ex_idx];
        target_d = target_q[ex_idx];
        kind_d   = kind_q[ex_idx];
        cnt_d    = cnt_q[ex_idx];
        if (valid_ex_i && is_ctrl) begin
            if (taken && !ex_match) begin
                btb_we   = 1'b1;
                tag_d    = ex_tag;
                target_d = alu_i;
                kind_d   = ex_kind;
                cnt_d    = CntWeak;
            end else if (taken) begin
                btb_we = 1'b1;
                // Return targets come from the RAS; keep the stored fallback
                if (kind_q[ex_idx] != KindRet) target_d = alu_i;
                if (cnt_q[ex_idx] != CntMax) cnt_d = cnt_q[ex_idx] + CNT_W'(1);
            end else if (is_br && ex_match) begin
                btb_we = 1'b1;
                if (cnt_q[ex_idx] != '0) cnt_d = cnt_q[ex_idx] - CNT_W'(1);
            end
        end
    end

    // RAS next state: push on link-rd call, pop on link-rs1 return, both => replace top
    always_comb begin
        ras_push  = valid_ex_i && (is_jal || is_jalr) && rd_link;
        ras_pop   = valid_ex_i && is_jalr && rs1_link && (!rd_link || (rd != rs1));
        ras_we    = 1'b0;
        ras_widx  = ras_ptr_q;
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;
        if (ras_push && ras_pop && (ras_cnt_q != '0)) begin
            ras_we   = 1'b1;
            ras_widx = ras_top_idx;
        end else if (ras_push) begin
            ras_we    = 1'b1;
            ras_ptr_d = ras_ptr_q + RAS_PW'(1);
            if (ras_cnt_q != RAS_CW'(RAS_DEPTH)) ras_cnt_d = ras_cnt_q + RAS_CW'(1);
        end else if (ras_pop && (ras_cnt_q != '0)) begin
            ras_ptr_d = ras_top_idx;
            ras_cnt_d = ras_cnt_q - RAS_CW'(1);
        end
    end

    // BTB state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                kind_q[i]   <= KindBr;
                cnt_q[i]    <= CntWeak;
            end
        end else if (btb_we) begin
            valid_q[ex_idx]  <= 1'b1;
            tag_q[ex_idx]    <= tag_d;
            target_q[ex_idx] <= target_d;
            kind_q[ex_idx]   <= kind_d;
            cnt_q[ex_idx]    <= cnt_d;
        end
    end

    // RAS state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
            for (int unsigned i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
        end else begin
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
            if (ras_we) ras_q[ras_widx] <= pc_ex_i + 32'd4;
        end
    end

    // Performance counters, wrapping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (valid_ex_i && is_ctrl) br_cnt_q <= br_cnt_q + PERF_W'(1);
            if (wrong_predicted_o != 2'b00) mispred_cnt_q <= mispred_cnt_q + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predictor_ras.sv
// Directed bench for branch_predictor_ras with default parameters.
module tb_branch_predictor_ras;

    logic        clk_i, rst_ni;
    logic [31:0] pc_i, predicted_pc_o;
    logic        hit_o;
    logic        valid_ex_i, br_eq_i, br_lt_i, hit_ex_i;
    logic [31:0] inst_ex_i, pc_ex_i, alu_i, pred_pc_ex_i, alu_pc_o;
    logic [1:0]  wrong_predicted_o;
    logic [31:0] br_cnt_o, mispred_cnt_o;

    int checks   = 0;
    int failures = 0;
    int exp_br   = 0;
    int exp_mis  = 0;

    branch_predictor_ras #(
        .ENTRIES(32), .CNT_W(2), .RAS_DEPTH(8), .PERF_W(32)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .pc_i(pc_i), .hit_o(hit_o),
        .predicted_pc_o(predicted_pc_o), .valid_ex_i(valid_ex_i), .inst_ex_i(inst_ex_i),
        .pc_ex_i(pc_ex_i), .br_eq_i(br_eq_i), .br_lt_i(br_lt_i), .alu_i(alu_i),
        .hit_ex_i(hit_ex_i), .pred_pc_ex_i(pred_pc_ex_i),
        .wrong_predicted_o(wrong_predicted_o), .alu_pc_o(alu_pc_o),
        .br_cnt_o(br_cnt_o), .mispred_cnt_o(mispred_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] b_inst(input logic [2:0] f3);
        return {17'b0, f3, 5'd0, 7'b1100011};
    endfunction
    function automatic logic [31:0] jal(input logic [4:0] rd);
        return {20'b0, rd, 7'b1101111};
    endfunction
    function automatic logic [31:0] jalr(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'b0, rs1, 3'b000, rd, 7'b1100111};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One EX cycle: drive mid-cycle, check comb outputs, commit on the next posedge
    task automatic ex(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                      input logic eq, input logic lt, input logic [31:0] alu,
                      input logic hit, input logic [31:0] pred,
                      input logic [1:0] exp_wrong, input bit ctrl);
        @(negedge clk_i);
        inst_ex_i = inst; pc_ex_i = pc; br_eq_i = eq; br_lt_i = lt;
        alu_i = alu; hit_ex_i = hit; pred_pc_ex_i = pred; valid_ex_i = 1'b1;
        #2;
        chk({tag, "_wrong"}, {30'b0, wrong_predicted_o}, {30'b0, exp_wrong});
        chk({tag, "_alu_pc"}, alu_pc_o, alu);
        if (ctrl) exp_br++;
        if (exp_wrong != 2'b00) exp_mis++;
        @(posedge clk_i);
        #1;
        valid_ex_i = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic h,
                        input logic [31:0] p);
        pc_i = pc;
        #1;
        chk({tag, "_hit"}, {31'b0, hit_o}, {31'b0, h});
        if (h) chk({tag, "_pred"}, predicted_pc_o, p);
    endtask

    task automatic counters(input string tag);
        chk({tag, "_br_cnt"}, br_cnt_o, exp_br);
        chk({tag, "_mis_cnt"}, mispred_cnt_o, exp_mis);
    endtask

    initial begin
        rst_ni = 1'b0; valid_ex_i = 1'b0; inst_ex_i = '0; pc_ex_i = '0; br_eq_i = 1'b0;
        br_lt_i = 1'b0; alu_i = '0; hit_ex_i = 1'b0; pred_pc_ex_i = '0; pc_i = 32'h100;
        #12;
        chk("rst_hit", {31'b0, hit_o}, 32'd0);
        chk("rst_pred", predicted_pc_o, 32'd0);
        chk("rst_wrong", {30'b0, wrong_predicted_o}, 32'd0);
        counters("rst");
        #5 rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // BEQ @0x100: allocate, then walk the counter 10->01->00->00->01->10->11->11->10
        ex("beq_t1", b_inst(3'b000), 32'h100, 1, 0, 32'h140, 0, 0, 2'b10, 1);
        look("beq_t1", 32'h100, 1, 32'h140);
        counters("beq_t1");
        ex("beq_n1", b_inst(3'b000), 32'h100, 0, 0, 32'h104, 1, 32'h140, 2'b01, 1);
        look("beq_n1", 32'h100, 0, 0);
        ex("beq_n2", b_inst(3'b000), 32'h100, 0, 0, 32'h104, 0, 0, 2'b00, 1);
        look("beq_n2", 32'h100, 0, 0);
        ex("beq_n3", b_inst(3'b000), 32'h100, 0, 0, 32'h104, 0, 0, 2'b00, 1);
        look("beq_n3", 32'h100, 0, 0);
        ex("beq_t2", b_inst(3'b000), 32'h100, 1, 0, 32'h140, 0, 0, 2'b10, 1);
        look("beq_t2", 32'h100, 0, 0);
        ex("beq_t3", b_inst(3'b000), 32'h100, 1, 0, 32'h140, 0, 0, 2'b10, 1);
        look("beq_t3", 32'h100, 1, 32'h140);
        ex("beq_t4", b_inst(3'b000), 32'h100, 1, 0, 32'h140, 1, 32'h140, 2'b00, 1);
        ex("beq_t5", b_inst(3'b000), 32'h100, 1, 0, 32'h140, 1, 32'h140, 2'b00, 1);
        ex("beq_n4", b_inst(3'b000), 32'h100, 0, 0, 32'h104, 1, 32'h140, 2'b01, 1);
        look("beq_n4", 32'h100, 1, 32'h140);
        counters("beq_n4");

        // Non-control instruction never mispredicts or counts
        ex("add", 32'h0000_0033, 32'h110, 1, 1, 32'h999, 1, 32'h0, 2'b00, 0);

        // funct3 decode: BLT taken, BGEU not taken (no allocation on miss)
        ex("blt", b_inst(3'b100), 32'h120, 0, 1, 32'h160, 0, 0, 2'b10, 1);
        look("blt", 32'h120, 1, 32'h160);
        ex("bgeu", b_inst(3'b111), 32'h124, 0, 1, 32'h128, 0, 0, 2'b00, 1);
        look("bgeu", 32'h124, 0, 0);

        // Aliasing: 0x180 shares the index of 0x100
        ex("alias", b_inst(3'b000), 32'h180, 1, 0, 32'h1c0, 0, 0, 2'b10, 1);
        look("alias_old", 32'h100, 0, 0);
        look("alias_new", 32'h180, 1, 32'h1c0);
        counters("alias");

        // Call / return
        ex("call1", jal(5'd1), 32'h208, 0, 0, 32'h400, 0, 0, 2'b10, 1);
        ex("ret1", jalr(5'd0, 5'd1), 32'h314, 0, 0, 32'h20c, 0, 0, 2'b10, 1);
        look("ret_empty", 32'h314, 1, 32'h20c);
        ex("call2", jal(5'd1), 32'h240, 0, 0, 32'h400, 0, 0, 2'b10, 1);
        look("ret_ras", 32'h314, 1, 32'h244);
        ex("ret2", jalr(5'd0, 5'd1), 32'h314, 0, 0, 32'h244, 1, 32'h244, 2'b00, 1);
        look("ret_popped", 32'h314, 1, 32'h20c);

        // Nine calls into an 8-deep stack: the first link is lost
        for (int k = 0; k < 9; k++) begin
            ex("call_n", jal((k % 2 == 1) ? 5'd5 : 5'd1), 32'h640 + 32'(4 * k), 0, 0,
               32'h800, 0, 0, 2'b10, 1);
        end
        for (int k = 8; k >= 1; k--) begin
            look("ras_pop", 32'h314, 1, 32'h644 + 32'(4 * k));
            ex("ret_n", jalr(5'd0, 5'd1), 32'h314, 0, 0, 32'h644 + 32'(4 * k), 1,
               32'h644 + 32'(4 * k), 2'b00, 1);
        end
        look("ras_drained", 32'h314, 1, 32'h20c);

        // Wrong target on a hit
        ex("jmp_alloc", jal(5'd0), 32'h700, 0, 0, 32'h400, 0, 0, 2'b10, 1);
        ex("jmp_wrong", jal(5'd0), 32'h700, 0, 0, 32'h480, 1, 32'h400, 2'b10, 1);
        look("jmp_wrong", 32'h700, 1, 32'h480);
        counters("jmp_wrong");

        // Reserved B-type funct3: not taken, no allocation
        ex("bres", b_inst(3'b010), 32'h188, 1, 1, 32'h200, 0, 0, 2'b00, 1);
        look("bres", 32'h188, 0, 0);
        chk("bres_mis_cnt", mispred_cnt_o, exp_mis);

        // Asynchronous reset mid-cycle
        look("pre_rst", 32'h314, 1, 32'h20c);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_hit", {31'b0, hit_o}, 32'd0);
        chk("arst_pred", predicted_pc_o, 32'd0);
        chk("arst_br_cnt", br_cnt_o, 32'd0);
        chk("arst_mis_cnt", mispred_cnt_o, 32'd0);
        #10 rst_ni = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
